word_clip_queue: RTL and testbench
==================================

// Module: word_clip_queue
// PURPOSE
//  Buffers detected word segments (start/end sample addresses) between the word clipper and the
//  downstream feature/classifier stage. Generalises the single-entry clipper output: DEPTH-entry
//  queue, length qualification (reject/clamp), and optional merging of adjacent segments.
//  Downstream handshake: orts (ready-to-send) / irtr (ready-to-receive).
// PARAMETERS
//  ADDR_W     32     address width of start/end
//  DEPTH      4      queue entries; power of 2, >=2
//  MIN_LEN    1      min word length in samples; shorter non-merged words are dropped
//  MAX_LEN    16000  max word length; longer words have end clamped to start+MAX_LEN-1
//  MERGE_EN   1      1: merge incoming word into newest queued entry when close enough
//  MERGE_GAP  0      max sample gap (istart - tail_end - 1) that still merges
// PORTS
//  iclk         in   1                       clock, rising edge
//  irstn        in   1                       asynchronous active-low reset
//  ivalid       in   1                       one-cycle strobe: istart_addr/iend_addr valid
//  istart_addr  in   ADDR_W                  word start address
//  iend_addr    in   ADDR_W                  word end address (inclusive)
//  orts         out  1                       head entry valid
//  ostart_addr  out  ADDR_W                  head start address
//  oend_addr    out  ADDR_W                  head end address
//  irtr         in   1                       downstream accepts head when orts && irtr
//  ocount       out  $clog2(DEPTH+1)         entries held
//  odrop        out  1                       pulse: input rejected (reversed or < MIN_LEN)
//  oclamp       out  1                       pulse: input/merged end clamped to MAX_LEN
//  ooverflow    out  1                       pulse: valid word lost, queue full, no pop
// BEHAVIOUR
//  Reset (irstn=0, async): rd/wr ptrs, ocount, all entries, orts, ostart_addr, oend_addr, odrop,
//   oclamp, ooverflow = 0. Reset mid-transfer discards all entries; no partial output.
//  Length arithmetic in ADDR_W+1 bits: len = iend - istart + 1; no wrap.
//  Qualification on ivalid, in order:
//   1 iend < istart -> odrop=1, nothing stored.
//   2 Merge: MERGE_EN && tail entry exists && tail not popped this cycle && istart >= tail_start
//     && istart <= tail_end+MERGE_GAP+1 -> tail_end = max(tail_end, iend), clamped to
//     tail_start+MAX_LEN-1 (oclamp=1 if clamped). ocount unchanged. MIN_LEN not checked.
//   3 len < MIN_LEN -> odrop=1.
//   4 len > MAX_LEN -> store with end = istart+MAX_LEN-1, oclamp=1.
//   5 Push: if count<DEPTH, or count==DEPTH with pop this cycle -> store at tail.
//     Otherwise ooverflow=1, word lost, queue unchanged.
//  Tail with count==1 being popped the same cycle: no merge, new word pushed as new entry.
//  Pop: orts && irtr -> rd ptr advance, ocount-1. Push+pop same cycle: ocount unchanged.
//  orts = (ocount != 0). ostart_addr/oend_addr show the head entry, registered (first-word
//   fall-through). Latency: ivalid at edge N into empty queue -> orts=1 and data at N+1.
//  Merging into the displayed head updates oend_addr next cycle; orts stays 1.
//  Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from ocount only.
//  odrop/oclamp/ooverflow: registered, high exactly one cycle after the causing ivalid.
//  ivalid=0: ignore inputs, including X values.
// STRUCTURE
//  word_clip_pkg: typedef struct packed {logic [ADDR_W-1:0] start_addr, end_addr;} clip_seg_t
//   (via parameterised class or macro); enum {QUAL_REJECT, QUAL_MERGE, QUAL_PUSH}.
//  Sub-module word_clip_qualify: combinational. Inputs: incoming word, tail entry, tail_valid.
//   Outputs: decision, final end, clamp flag.
//  Top module: storage array, pointers, count, registered outputs, handshake.
// TESTING
//  T1 reset, (2,3) strobe, irtr held 0 for 7 cycles, then 1 cycle ->
//     orts=1 from N+1 with (2,3); popped on irtr; orts=0 and ocount=0 after.
//  T2 DEPTH=4, MERGE_EN=0: push (0,9),(20,29),(40,49),(60,69),(80,89) with irtr=0 ->
//     ooverflow on the 5th only; pops return the first four in order.
//  T3 full queue, 5th ivalid with irtr=1 the same cycle -> no overflow, ocount stays 4, order kept.
//  T4 MIN_LEN=4, MAX_LEN=100: (10,5) -> odrop; (10,11) -> odrop; (0,199) -> stored (0,99), oclamp.
//  T5 MERGE_GAP=2, head (0,9) unpopped: (12,15) -> merged (0,15), ocount=1;
//     then (19,20) -> new entry (gap 3).
//  T6 irstn pulsed low mid-stream with 3 entries held -> all outputs 0 immediately (async);
//     next ivalid behaves as the first word after reset.

Source files
------------

// File: rtl/word_clip_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// word_clip_pkg : shared types for the word segment queue
// Revision      : 1.0
// ----------------------------------------------------------------------------

// Packages cannot take parameters, so the segment struct is built per-width here.
`define WORD_CLIP_SEG_T(W) struct packed { logic [(W)-1:0] start_addr; logic [(W)-1:0] end_addr; }

package word_clip_pkg;

    typedef enum logic [1:0] {
        QUAL_REJECT = 2'd0,
        QUAL_MERGE  = 2'd1,
        QUAL_PUSH   = 2'd2
    } qual_t;

    function automatic logic is_decision(input logic [1:0] value, input qual_t kind);
        return value == kind;
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_clip_qualify.sv
`default_nettype none
// ----------------------------------------------------------------------------
// word_clip_qualify : length check, clamp and merge decision for one word
// Revision          : 1.0
// ----------------------------------------------------------------------------
module word_clip_qualify
    import word_clip_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MIN_LEN   = 1,
    parameter int MAX_LEN   = 16000,
    parameter int MERGE_EN  = 1,
    parameter int MERGE_GAP = 0
) (
    input  logic [ADDR_W-1:0] in_start,
    input  logic [ADDR_W-1:0] in_end,
    input  logic [ADDR_W-1:0] tail_start,
    input  logic [ADDR_W-1:0] tail_end,
    input  logic              tail_valid,
    output logic [1:0]        decision,
    output logic [ADDR_W-1:0] final_end,
    output logic              clamp
);

    localparam int EXT_W = ADDR_W + 1;

    logic [EXT_W-1:0]  start_x;
    logic [EXT_W-1:0]  end_x;
    logic [EXT_W-1:0]  tail_start_x;
    logic [EXT_W-1:0]  tail_end_x;
    logic [EXT_W-1:0]  word_len;
    logic [EXT_W-1:0]  merge_reach;
    logic [EXT_W-1:0]  merge_lim_x;
    logic [ADDR_W-1:0] merge_lim;
    logic [ADDR_W-1:0] merge_max;
    logic [ADDR_W-1:0] push_lim;
    logic              reversed;
    logic              merge_hit;

    assign start_x      = {1'b0, in_start};
    assign end_x        = {1'b0, in_end};
    assign tail_start_x = {1'b0, tail_start};
    assign tail_end_x   = {1'b0, tail_end};

    // Comparisons use the extended width; the clamp limits are only emitted
    // when smaller than a value that fits, so ADDR_W bits are exact there.
    assign word_len    = end_x - start_x + EXT_W'(1);
    assign merge_reach = tail_end_x + EXT_W'(MERGE_GAP) + EXT_W'(1);
    assign merge_lim_x = tail_start_x + EXT_W'(MAX_LEN) - EXT_W'(1);
    assign merge_lim   = tail_start + ADDR_W'(MAX_LEN - 1);
    assign push_lim    = in_start + ADDR_W'(MAX_LEN - 1);
    assign merge_max   = (in_end > tail_end) ? in_end : tail_end;

    assign reversed  = end_x < start_x;
    assign merge_hit = (MERGE_EN != 0) && tail_valid &&
                       (start_x >= tail_start_x) && (start_x <= merge_reach);

    always_comb begin
        decision  = QUAL_REJECT;
        final_end = in_end;
        clamp     = 1'b0;
        if (reversed) begin
            decision = QUAL_REJECT;
        end else if (merge_hit) begin
            decision = QUAL_MERGE;
            if ({1'b0, merge_max} > merge_lim_x) begin
                final_end = merge_lim;
                clamp     = 1'b1;
            end else begin
                final_end = merge_max;
            end
        end else if (word_len < EXT_W'(MIN_LEN)) begin
            decision = QUAL_REJECT;
        end else begin
            decision = QUAL_PUSH;
            if (word_len > EXT_W'(MAX_LEN)) begin
                final_end = push_lim;
                clamp     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_clip_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// word_clip_queue : DEPTH-entry queue of word segments with merge/clamp/drop
// Revision        : 1.0
// ----------------------------------------------------------------------------
module word_clip_queue
    import word_clip_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4,
    parameter int MIN_LEN   = 1,
    parameter int MAX_LEN   = 16000,
    parameter int MERGE_EN  = 1,
    parameter int MERGE_GAP = 0
) (
    input  logic                         iclk,
    input  logic                         irstn,
    input  logic                         ivalid,
    input  logic [ADDR_W-1:0]            istart_addr,
    input  logic [ADDR_W-1:0]            iend_addr,
    output logic                         orts,
    output logic [ADDR_W-1:0]            ostart_addr,
    output logic [ADDR_W-1:0]            oend_addr,
    input  logic                         irtr,
    output logic [$clog2(DEPTH+1)-1:0]   ocount,
    output logic                         odrop,
    output logic                         oclamp,
    output logic                         ooverflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef `WORD_CLIP_SEG_T(ADDR_W) clip_seg_t;

    clip_seg_t         mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [PTR_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  count_next;
    logic [1:0]        decision;
    logic [ADDR_W-1:0] final_end;
    logic              qual_clamp;
    logic              pop;
    logic              full;
    logic              tail_valid;
    logic              want_push;
    logic              do_push;
    logic              do_merge;
    logic              overflow_now;
    logic              wr_en;
    clip_seg_t         wr_seg;
    clip_seg_t         head_next;

    assign orts     = (ocount != '0);
    assign pop      = orts && irtr;
    assign full     = (ocount == CNT_W'(DEPTH));
    assign tail_ptr = wr_ptr - PTR_W'(1);

    // A single entry leaving this cycle cannot absorb the incoming word.
    assign tail_valid = orts && !(pop && (ocount == CNT_W'(1)));

    word_clip_qualify #(
        .ADDR_W    (ADDR_W),
        .MIN_LEN   (MIN_LEN),
        .MAX_LEN   (MAX_LEN),
        .MERGE_EN  (MERGE_EN),
        .MERGE_GAP (MERGE_GAP)
    ) u_qualify (
        .in_start   (istart_addr),
        .in_end     (iend_addr),
        .tail_start (mem[tail_ptr].start_addr),
        .tail_end   (mem[tail_ptr].end_addr),
        .tail_valid (tail_valid),
        .decision   (decision),
        .final_end  (final_end),
        .clamp      (qual_clamp)
    );

    assign do_merge     = ivalid && is_decision(decision, QUAL_MERGE);
    assign want_push    = ivalid && is_decision(decision, QUAL_PUSH);
    assign do_push      = want_push && (!full || pop);
    assign overflow_now = want_push && full && !pop;

    assign wr_en             = do_push || do_merge;
    assign wr_idx            = do_merge ? tail_ptr : wr_ptr;
    assign wr_seg.start_addr = do_merge ? mem[tail_ptr].start_addr : istart_addr;
    assign wr_seg.end_addr   = final_end;

    // The head registers must see this cycle's write when it lands on the
    // entry that will be at the head after the pop.
    assign rd_next   = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    assign head_next = (wr_en && (wr_idx == rd_next)) ? wr_seg : mem[rd_next];

    always_comb begin
        count_next = ocount;
        if (do_push && !pop) begin
            count_next = ocount + CNT_W'(1);
        end else if (!do_push && pop) begin
            count_next = ocount - CNT_W'(1);
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            ocount      <= '0;
            ostart_addr <= '0;
            oend_addr   <= '0;
            odrop       <= 1'b0;
            oclamp      <= 1'b0;
            ooverflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_seg;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr      <= rd_next;
            ocount      <= count_next;
            ostart_addr <= head_next.start_addr;
            oend_addr   <= head_next.end_addr;
            odrop       <= ivalid && is_decision(decision, QUAL_REJECT);
            oclamp      <= (do_merge || want_push) && qual_clamp;
            ooverflow   <= overflow_now;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_word_clip_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_word_clip_queue : directed vectors, scoreboard-checked output stream
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_word_clip_queue;

    // One parameter set covers every scenario: MIN_LEN=4, MAX_LEN=100, GAP=2.
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] e;
    } seg_t;

    logic              clk;
    logic              rstn;
    logic              ivalid;
    logic [ADDR_W-1:0] istart;
    logic [ADDR_W-1:0] iend;
    logic              orts;
    logic [ADDR_W-1:0] ostart;
    logic [ADDR_W-1:0] oend;
    logic              irtr;
    logic [2:0]        ocount;
    logic              odrop;
    logic              oclamp;
    logic              ooverflow;

    int   checks = 0;
    int   errors = 0;
    seg_t exp_q[$];

    word_clip_queue #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .MIN_LEN   (4),
        .MAX_LEN   (100),
        .MERGE_EN  (1),
        .MERGE_GAP (2)
    ) dut (
        .iclk        (clk),
        .irstn       (rstn),
        .ivalid      (ivalid),
        .istart_addr (istart),
        .iend_addr   (iend),
        .orts        (orts),
        .ostart_addr (ostart),
        .oend_addr   (oend),
        .irtr        (irtr),
        .ocount      (ocount),
        .odrop       (odrop),
        .oclamp      (oclamp),
        .ooverflow   (ooverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever orts && irtr
    // is seen here, so the head is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && orts && irtr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got (%0d,%0d) expected no entry", ostart, oend);
            end else begin
                seg_t x;
                x = exp_q.pop_front();
                chk("pop_start", ostart, x.s);
                chk("pop_end", oend, x.e);
            end
        end
    end

    // act: 0 nothing stored, 1 new entry (s,exp_end), 2 newest entry end -> exp_end
    task automatic drive(input logic [31:0] s, input logic [31:0] e, input logic rtr,
                         input logic [31:0] exp_end, input int act,
                         input logic ed, input logic ec, input logic eo);
        if (act == 1) begin
            exp_q.push_back('{s: s, e: exp_end});
        end else if (act == 2 && exp_q.size() != 0) begin
            seg_t t;
            t   = exp_q[exp_q.size()-1];
            t.e = exp_end;
            exp_q[exp_q.size()-1] = t;
        end
        ivalid = 1'b1;
        istart = s;
        iend   = e;
        irtr   = rtr;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        istart = 'x;
        iend   = 'x;
        irtr   = 1'b0;
        chk("odrop", odrop, ed);
        chk("oclamp", oclamp, ec);
        chk("ooverflow", ooverflow, eo);
    endtask

    task automatic idle(input int n, input logic rtr);
        repeat (n) begin
            irtr = rtr;
            @(posedge clk);
            #1;
        end
        irtr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(1, 1'b1);
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_count", ocount, 0);
        chk("drain_orts", orts, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b0;
        ivalid = 1'b0;
        irtr   = 1'b0;
        istart = '0;
        iend   = '0;
        #12;
        chk("rst_orts", orts, 0);
        chk("rst_count", ocount, 0);
        chk("rst_start", ostart, 0);
        chk("rst_end", oend, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // T1: single word, held 7 cycles, then taken
        drive(2, 5, 0, 5, 1, 0, 0, 0);
        chk("t1_orts", orts, 1);
        chk("t1_count", ocount, 1);
        chk("t1_start", ostart, 2);
        chk("t1_end", oend, 5);
        idle(6, 1'b0);
        chk("t1_hold", orts, 1);
        idle(1, 1'b1);
        chk("t1_orts_after", orts, 0);
        chk("t1_count_after", ocount, 0);

        // T2: fill, fifth word overflows
        drive(0, 9, 0, 9, 1, 0, 0, 0);
        drive(20, 29, 0, 29, 1, 0, 0, 0);
        drive(40, 49, 0, 49, 1, 0, 0, 0);
        drive(60, 69, 0, 69, 1, 0, 0, 0);
        chk("t2_full", ocount, 4);
        drive(80, 89, 0, 89, 0, 0, 0, 1);
        chk("t2_count", ocount, 4);
        chk("t2_head", ostart, 0);

        // T3: full queue, push with simultaneous pop
        drive(100, 109, 1, 109, 1, 0, 0, 0);
        chk("t3_count", ocount, 4);
        chk("t3_head", ostart, 20);
        drain();

        // T4: reversed, too short, too long
        drive(10, 5, 0, 0, 0, 1, 0, 0);
        drive(10, 11, 0, 0, 0, 1, 0, 0);
        chk("t4_empty", ocount, 0);
        drive(0, 199, 0, 99, 1, 0, 1, 0);
        chk("t4_count", ocount, 1);
        chk("t4_end", oend, 99);
        drain();

        // T5: merge into displayed head, then gap too large, then clamped merge
        drive(0, 9, 0, 9, 1, 0, 0, 0);
        drive(12, 15, 0, 15, 2, 0, 0, 0);
        chk("t5_count", ocount, 1);
        chk("t5_orts", orts, 1);
        chk("t5_end", oend, 15);
        drive(19, 22, 0, 22, 1, 0, 0, 0);
        chk("t5_count2", ocount, 2);
        drive(20, 150, 0, 118, 2, 0, 1, 0);
        chk("t5_count3", ocount, 2);
        drain();

        // Sole entry popped while a mergeable word arrives: becomes a new entry
        drive(200, 209, 0, 209, 1, 0, 0, 0);
        drive(205, 210, 1, 210, 1, 0, 0, 0);
        chk("nomerge_count", ocount, 1);
        chk("nomerge_start", ostart, 205);
        chk("nomerge_end", oend, 210);
        drain();

        // T6: asynchronous reset with three entries held
        drive(0, 9, 0, 9, 1, 0, 0, 0);
        drive(20, 29, 0, 29, 1, 0, 0, 0);
        drive(40, 49, 0, 49, 1, 0, 0, 0);
        chk("t6_count", ocount, 3);
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_orts", orts, 0);
        chk("t6_count_rst", ocount, 0);
        chk("t6_start", ostart, 0);
        chk("t6_end", oend, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t6_hold", ocount, 0);
        rstn = 1'b1;
        drive(2, 5, 0, 5, 1, 0, 0, 0);
        chk("t6_first_count", ocount, 1);
        chk("t6_first_start", ostart, 2);
        chk("t6_first_end", oend, 5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
